// File: rtl/note_sched_pkg.sv
// Shared types and helpers for the note/mode scheduler.
package note_sched_pkg;

  typedef enum logic [1:0] {IDLE, CONFIRM, PENDING} state_t;

  typedef enum logic [1:0] {BARS, HYPERBOLA, CIRCLE, DEFAULT} mode_t;

  // Highest note index that counts as a real note; 12..15 are ignored.
  localparam logic [3:0] NOTE_MAX = 4'd11;

  // Pattern selected by a note: cycles through the three drawable patterns.
  function automatic mode_t note_to_mode(input logic [3:0] n);
    return mode_t'(2'(n % 4'd3));
  endfunction

endpackage

// File: rtl/tick_strobe_gen.sv
// Free-running prescaler producing a registered one-cycle tick on each wrap.
module tick_strobe_gen #(
  parameter int tick_log2 = 20
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [tick_log2-1:0] cnt;

  // Tick goes high in the cycle right after the counter wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt + tick_log2'(1);
      tick <= (cnt == '1);
    end
  end

endmodule

// File: rtl/note_mode_scheduler.sv
// Confirms a stable note, defers the pattern switch to a frame boundary and
// runs the animation position counters on the prescaler tick.
module note_mode_scheduler
  import note_sched_pkg::*;
#(
  parameter int clk_mhz       = 50,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int tick_log2     = 20,
  parameter int confirm_cnt   = 3,
  parameter int timeout_ticks = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           note_vld,
  input  logic [3:0]     note_idx,
  input  logic           frame_start,
  input  logic           key_up,
  input  logic           key_down,
  output logic [3:0]     note_q,
  output logic [1:0]     mode,
  output logic [w_x-1:0] cnt1,
  output logic [w_y-1:0] cnt2,
  output logic           tick,
  output logic           busy
);

  localparam int MW = (confirm_cnt   < 1) ? 1 : $clog2(confirm_cnt + 1);
  localparam int TW = (timeout_ticks < 1) ? 1 : $clog2(timeout_ticks + 1);

  state_t        state, state_n;
  mode_t         mode_r;
  logic [3:0]    cand, cand_n;
  logic [MW-1:0] match, match_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          valid, commit;

  tick_strobe_gen #(.tick_log2(tick_log2)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Out-of-range indices behave as if no event arrived.
  assign valid = note_vld && (note_idx <= NOTE_MAX);
  assign mode  = mode_r;

  // Next-state logic: confirmation counting, timeout and frame-aligned commit.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    match_n = match;
    tmo_n   = tmo;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (valid && note_idx != note_q) begin
          cand_n  = note_idx;
          match_n = MW'(1);
          tmo_n   = '0;
          state_n = (confirm_cnt == 1) ? PENDING : CONFIRM;
        end
      end
      CONFIRM: begin
        if (valid) begin
          if (note_idx == cand) begin
            match_n = match + MW'(1);
            if (match_n == MW'(confirm_cnt)) state_n = PENDING;
          end else if (note_idx == note_q) begin
            state_n = IDLE;
          end else begin
            cand_n  = note_idx;
            match_n = MW'(1);
            tmo_n   = '0;
          end
        end else if (tick) begin
          tmo_n = tmo + TW'(1);
          if (tmo_n == TW'(timeout_ticks)) state_n = IDLE;
        end
      end
      PENDING: begin
        if (frame_start) begin
          commit  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM, committed note/mode and confirmation bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      cand   <= '0;
      match  <= '0;
      tmo    <= '0;
      note_q <= 4'hF;
      mode_r <= DEFAULT;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      cand  <= cand_n;
      match <= match_n;
      tmo   <= tmo_n;
      if (commit) begin
        note_q <= cand;
        mode_r <= note_to_mode(cand);
      end
    end
  end

  // Animation counters; a commit restarts the horizontal sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1 <= '0;
      cnt2 <= w_y'(screen_height / 2);
    end else begin
      if (commit)
        cnt1 <= '0;
      else if (tick)
        cnt1 <= (cnt1 == w_x'(screen_width - 1)) ? '0 : cnt1 + w_x'(1);
      if (tick) begin
        if (cnt2 == '0 || cnt2 == w_y'(screen_height - 1))
          cnt2 <= w_y'(screen_height / 2);
        else
          cnt2 <= cnt2 + w_y'(key_up) - w_y'(key_down);
      end
    end
  end

endmodule

// File: tb/tb_note_mode_scheduler.sv
// Directed bench for note_mode_scheduler with a short prescaler.
module tb_note_mode_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       note_vld = 1'b0;
  logic [3:0] note_idx = 4'd0;
  logic       frame_start = 1'b0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic [3:0] note_q;
  logic [1:0] mode;
  logic [9:0] cnt1;
  logic [8:0] cnt2;
  logic       tick;
  logic       busy;

  int tests = 0;
  int fails = 0;

  note_mode_scheduler #(
    .tick_log2     (4),
    .confirm_cnt   (3),
    .timeout_ticks (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .note_vld    (note_vld),
    .note_idx    (note_idx),
    .frame_start (frame_start),
    .key_up      (key_up),
    .key_down    (key_down),
    .note_q      (note_q),
    .mode        (mode),
    .cnt1        (cnt1),
    .cnt2        (cnt2),
    .tick        (tick),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_note(input int idx, input bit with_frame);
    note_vld    = 1'b1;
    note_idx    = 4'(idx);
    frame_start = with_frame;
    cyc(1);
    note_vld    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  // Let n ticks be consumed by the counters; each wait is bounded.
  task automatic pass_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int b = 0;
      while (tick !== 1'b1 && b < 40) begin
        cyc(1);
        b++;
      end
      if (b >= 40) begin
        tests++;
        fails++;
        $error("FAIL tick_timeout: observed no tick in %0d cycles expected a tick", b);
        return;
      end
      cyc(1);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_mode", mode, 3);
    chk("rst_note_q", note_q, 15);
    chk("rst_cnt2", cnt2, 240);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Prescaler: first tick after 16 edges, counters advance on it.
    cyc(15);
    chk("tick_before_16", tick, 0);
    cyc(1);
    chk("tick_at_16", tick, 1);
    chk("cnt1_pre_tick", cnt1, 0);
    cyc(1);
    chk("tick_one_cycle", tick, 0);
    chk("cnt1_first_tick", cnt1, 1);
    pass_ticks(638);
    chk("cnt1_639", cnt1, 639);
    pass_ticks(1);
    chk("cnt1_wrap", cnt1, 0);
    pass_ticks(5);
    chk("cnt1_5", cnt1, 5);

    // Out-of-range index is ignored.
    send_note(13, 1'b0);
    chk("ignore_13_busy", busy, 0);

    // Three matching notes, then commit on frame_start.
    send_note(4, 1'b0);
    chk("confirm_busy", busy, 1);
    send_note(4, 1'b0);
    send_note(4, 1'b0);
    chk("pending_busy", busy, 1);
    chk("pending_mode_held", mode, 3);
    pulse_frame();
    chk("commit4_busy", busy, 0);
    chk("commit4_mode", mode, 1);
    chk("commit4_note_q", note_q, 4);
    chk("commit4_cnt1", cnt1, 0);

    // Candidate change: 5,5,7 restarts counting at 7.
    send_note(5, 1'b0);
    send_note(5, 1'b0);
    send_note(7, 1'b0);
    send_note(7, 1'b0);
    pulse_frame();
    chk("cand7_no_commit", note_q, 4);
    chk("cand7_still_busy", busy, 1);
    send_note(7, 1'b1);
    chk("same_cycle_frame_note_q", note_q, 4);
    chk("same_cycle_frame_busy", busy, 1);
    pulse_frame();
    chk("commit7_mode", mode, 1);
    chk("commit7_note_q", note_q, 7);
    chk("commit7_busy", busy, 0);

    // Timeout after 8 ticks without events.
    send_note(2, 1'b0);
    chk("tmo_busy", busy, 1);
    pass_ticks(7);
    chk("tmo_7_busy", busy, 1);
    pass_ticks(1);
    chk("tmo_8_idle", busy, 0);
    pulse_frame();
    chk("tmo_mode_kept", mode, 1);
    chk("tmo_note_q_kept", note_q, 7);

    // Vertical counter with keys.
    key_up = 1'b1;
    pass_ticks(238);
    chk("cnt2_478", cnt2, 478);
    pass_ticks(1);
    chk("cnt2_479", cnt2, 479);
    pass_ticks(1);
    chk("cnt2_recenter", cnt2, 240);
    pass_ticks(5);
    chk("cnt2_245", cnt2, 245);
    key_down = 1'b1;
    pass_ticks(3);
    chk("cnt2_both_keys", cnt2, 245);
    key_up = 1'b0;
    pass_ticks(1);
    chk("cnt2_down", cnt2, 244);
    key_down = 1'b0;

    // Reset while pending aborts the commit.
    send_note(9, 1'b0);
    send_note(9, 1'b0);
    send_note(9, 1'b0);
    chk("pend9_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mode", mode, 3);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    pulse_frame();
    chk("post_rst_mode", mode, 3);
    chk("post_rst_note_q", note_q, 15);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt2", cnt2, 240);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
